baud_gen: RTL and testbench

//  - Programmable baud-rate tick generator for the UART SoC, sitting between the system clock and the UART TX/RX engines.
//  - A 12-bit divisor {dlh,dll}, written by the register file's divisor latches, sets the tick period in clk cycles.
//  - Emits a one-cycle br strobe per period and exposes the running count for debug/verification.

---
 rtl/uart_pkg.sv | 11 +
 rtl/baud_gen.sv | 36 +++
 tb/tb_baud_gen.sv | 112 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared widths and divisor type for the UART baud-rate generator
package uart_pkg;
  localparam int DLL_W = 8;
  localparam int DLH_W = 4;
  localparam int DIV_W = 12;
  localparam int CNT_W = 16;
  typedef logic [DIV_W-1:0] div_t;
  function automatic div_t mk_div(input logic [DLH_W-1:0] hi, input logic [DLL_W-1:0] lo);
    return {hi, lo};
  endfunction
endpackage

// File: rtl/baud_gen.sv
// baud_gen: programmable baud tick generator, divisor {dlh,dll} sets period in clk cycles
//  clk, rst (sync, active-high); dll/dlh divisor latches; br tick/square output; counter phase within period
//  BAUD_GEN_SQUARE_OUT_EN defined: br toggles at each terminal count instead of pulsing
module baud_gen
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [DLL_W-1:0] dll,
  input  logic [DLH_W-1:0] dlh,
  output logic             br,
  output logic [CNT_W-1:0] counter
);
  div_t div_q, div_in, div_m1;
  logic idle, tc;
  assign div_in = mk_div(dlh, dll);
  assign idle   = div_q == '0;
  assign div_m1 = div_q - DIV_W'(1);
  assign tc     = !idle && counter == CNT_W'(div_m1);
  // shadow divisor only follows the latches at period boundaries or while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= div_in;
      counter <= '0;
      br      <= 1'b0;
    end else begin
      div_q   <= (tc || idle) ? div_in : div_q;
      counter <= (tc || idle) ? '0 : counter + CNT_W'(1);
`ifdef BAUD_GEN_SQUARE_OUT_EN
      br      <= tc ? ~br : br;
`else
      br      <= tc;
`endif
    end
  end
endmodule

// File: tb/tb_baud_gen.sv
// tb_baud_gen: randomized and directed checks of baud_gen against a period-based reference model
module tb_baud_gen;
  logic clk = 1'b0, rst = 1'b1, br;
  logic [7:0] dll = 8'd6;
  logic [3:0] dlh = 4'd0;
  logic [15:0] counter;
  int total = 0, passed = 0;
  int m_len = 0, m_el = 0;
  logic m_br = 1'b0;
  int max_cnt = 0;
  baud_gen dut (.clk(clk), .rst(rst), .dll(dll), .dlh(dlh), .br(br), .counter(counter));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) begin passed++; end
    else $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask
  // model: a period of length m_len (captured from the latches when it starts) elapses m_el cycles
  task automatic step();
    logic r;
    int d;
    logic done;
    r = rst;
    d = {dlh, dll};
    @(posedge clk);
    #1;
    done = 1'b0;
    if (r) begin
      m_len = d; m_el = 0; m_br = 1'b0;
    end else if (m_len == 0) begin
      m_len = d; m_el = 0;
    end else if (m_el + 1 >= m_len) begin
      done = 1'b1; m_len = d; m_el = 0;
    end else m_el++;
`ifdef BAUD_GEN_SQUARE_OUT_EN
    if (done) m_br = ~m_br;
`else
    m_br = done;
`endif
    if (int'(counter) > max_cnt) max_cnt = int'(counter);
    chk("counter", int'(counter), m_el);
    chk("br", int'(br), int'(m_br));
  endtask
  task automatic wait_cnt(input int v);
    int n;
    n = 0;
    while (int'(counter) != v && n < 5000) begin step(); n++; end
    chk("wait_counter_reached", int'(counter), v);
  endtask
  initial begin
    int ticks, prev;
    // 1: reset then count 0..5
    rst = 1'b1; dll = 8'd6; dlh = 4'd0;
    step(); step();
    chk("reset_counter", int'(counter), 0);
    chk("reset_br", int'(br), 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step();
    // 2: one event per 6 cycles over a 60-cycle window
    ticks = 0; prev = int'(br);
    for (int i = 0; i < 60; i++) begin
      step();
`ifdef BAUD_GEN_SQUARE_OUT_EN
      if (int'(br) != prev) ticks++;
`else
      if (br) ticks++;
`endif
      prev = int'(br);
    end
    chk("ticks_per_60_div6", ticks, 10);
    // 3: maximum divisor 4095
    dll = 8'hFF; dlh = 4'hF;
    max_cnt = 0;
    for (int i = 0; i < 2 * 4095 + 10; i++) step();
    chk("max_counter_4094", max_cnt, 4094);
    // 4: mid-period divisor change
    dll = 8'd6; dlh = 4'd0;
    wait_cnt(0);
    for (int i = 0; i < 8; i++) step();
    wait_cnt(2);
    dll = 8'd3;
    for (int i = 0; i < 12; i++) step();
    // 5: idle divisor then divisor 1
    dll = 8'd0;
    for (int i = 0; i < 20; i++) step();
    chk("idle_counter", int'(counter), 0);
    chk("idle_br", int'(br), 0);
    dll = 8'd1;
    for (int i = 0; i < 10; i++) step();
    // 6: reset mid-period drops pending tick
    dll = 8'd6;
    for (int i = 0; i < 8; i++) step();
    wait_cnt(4);
    rst = 1'b1;
    step();
    chk("midrst_counter", int'(counter), 0);
    chk("midrst_br", int'(br), 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    // randomized divisor changes and occasional resets
    for (int s = 0; s < 40; s++) begin
      dll = 8'($urandom_range(0, 12));
      dlh = ($urandom_range(0, 9) == 0) ? 4'd1 : 4'd0;
      rst = ($urandom_range(0, 7) == 0);
      step();
      rst = 1'b0;
      for (int i = 0; i < int'($urandom_range(5, 60)); i++) step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
